// File: rtl/inst_fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
// Imported by the fetch interface and the fetch stage itself.
package inst_fetch_pkg;

  localparam int          INST_W       = 32;
  localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;
  localparam int          NMEM_DEF     = 256;
  localparam logic [31:0] NOP          = 32'h0000_0000;

  typedef enum logic {
    S_RUN   = 1'b0,
    S_FAULT = 1'b1
  } state_t;

  typedef struct packed {
    logic [INST_W-1:0] inst;
    logic [31:0]       pc;
    logic [31:0]       pc4;
  } if_id_t;

  // Misaligned, or beyond the last word backing im.
  function automatic logic is_bad(
    input logic [31:0] pc,
    input logic [31:0] nmem
  );
    return (pc[1:0] != 2'b00) ||
           ({2'b00, pc[31:2]} >= nmem);
  endfunction

endpackage

// File: rtl/inst_fetch_if.sv
// Fetch-to-decode valid/ready bundle.
// Fetch is the master, decode the slave.
interface inst_fetch_if;
  import inst_fetch_pkg::*;

  logic              out_valid;
  logic              out_ready;
  logic [INST_W-1:0] out_inst;
  logic [31:0]       out_pc;
  logic [31:0]       out_pc4;

  modport master (
    output out_valid,
    output out_inst,
    output out_pc,
    output out_pc4,
    input  out_ready
  );

  modport slave (
    input  out_valid,
    input  out_inst,
    input  out_pc,
    input  out_pc4,
    output out_ready
  );

endinterface

// File: rtl/inst_fetch.sv
// Instruction-fetch stage: owns the pc, reads im,
// registers the word for decode, traps bad pcs.
module inst_fetch
  import inst_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEF,
  parameter int          NMEM     = NMEM_DEF
) (
  input  logic              clk,
  input  logic              rst,
  output logic [31:0]       im_addr,
  input  logic [INST_W-1:0] im_data,
  input  logic              redirect_valid,
  input  logic [31:0]       redirect_pc,
  inst_fetch_if.master      dec,
  output logic              fault,
  output logic [31:0]       fault_pc
);

  localparam logic [31:0] NMEM_W = 32'(NMEM);

  state_t      state;
  state_t      state_nxt;
  logic [31:0] pc;
  if_id_t      ifid;
  logic        out_valid;
  logic        bad;
  logic        can_load;
  logic        fetch_en;
  logic        fault_set;

  assign im_addr  = pc;
  assign bad      = is_bad(pc, NMEM_W);
  assign can_load = !out_valid || dec.out_ready;
  assign fault    = (state == S_FAULT);

  assign dec.out_valid = out_valid;
  assign dec.out_inst  = ifid.inst;
  assign dec.out_pc    = ifid.pc;
  assign dec.out_pc4   = ifid.pc4;

  // Next state: redirect always returns to RUN; RUN fetches or traps.
  always_comb begin
    state_nxt = state;
    fetch_en  = 1'b0;
    fault_set = 1'b0;
    if (redirect_valid) begin
      state_nxt = S_RUN;
    end else begin
      unique case (state)
        S_RUN: begin
          if (can_load) begin
            if (bad) begin
              state_nxt = S_FAULT;
              fault_set = 1'b1;
            end else begin
              fetch_en = 1'b1;
            end
          end
        end
        S_FAULT: begin
          state_nxt = S_FAULT;
        end
      endcase
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= S_RUN;
    else     state <= state_nxt;
  end

  // PC: reset, redirect target, or advance on a successful fetch.
  always_ff @(posedge clk) begin
    if (rst)                 pc <= RESET_PC;
    else if (redirect_valid) pc <= redirect_pc;
    else if (fetch_en)       pc <= pc + 32'd4;
  end

  // IF/ID register; redirect flushes only the not-yet-taken slot.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      ifid      <= '{inst: NOP, pc: 32'd0, pc4: 32'd0};
    end else if (redirect_valid) begin
      out_valid <= 1'b0;
    end else if (fetch_en) begin
      out_valid <= 1'b1;
      ifid      <= '{inst: im_data, pc: pc, pc4: pc + 32'd4};
    end else if (fault_set || (out_valid && dec.out_ready)) begin
      out_valid <= 1'b0;
    end
  end

  // Remember which pc trapped; survives redirect for post-mortem.
  always_ff @(posedge clk) begin
    if (rst)            fault_pc <= 32'd0;
    else if (fault_set) fault_pc <= pc;
  end

endmodule

// File: tb/tb_inst_fetch.sv
// Directed bench for inst_fetch with an im model
// and an in-order scoreboard on decode transfers.
module tb_inst_fetch;

  localparam int NMEM = 256;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
  } sb_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] im_addr;
  logic [31:0] im_data;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = 32'd0;
  logic        fault;
  logic [31:0] fault_pc;

  int checks = 0;
  int errors = 0;
  sb_t q[$];

  inst_fetch_if dec();

  inst_fetch #(
    .RESET_PC(32'h0000_0000),
    .NMEM(NMEM)
  ) dut (
    .clk(clk),
    .rst(rst),
    .im_addr(im_addr),
    .im_data(im_data),
    .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc),
    .dec(dec),
    .fault(fault),
    .fault_pc(fault_pc)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] word(input logic [31:0] a);
    case (a[31:2])
      30'd0:   return 32'h11;
      30'd1:   return 32'h22;
      30'd2:   return 32'h33;
      30'd3:   return 32'h44;
      default: return 32'hA000_0000 | {2'b00, a[31:2]};
    endcase
  endfunction

  assign im_data = (im_addr[31:2] < 30'(NMEM)) ?
                   word(im_addr) : 32'hDEAD_BEEF;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [31:0] a);
    sb_t e;
    e.pc   = a;
    e.inst = word(a);
    q.push_back(e);
  endtask

  // Scoreboard: every decode transfer must match the next expected word.
  always @(negedge clk) begin
    if (!rst && dec.out_valid === 1'b1 && dec.out_ready === 1'b1) begin
      sb_t e;
      checks++;
      assert (q.size() != 0) else begin
        errors++;
        $error("FAIL sb_extra: got pc %h expected none", dec.out_pc);
      end
      if (q.size() != 0) begin
        e = q.pop_front();
        chk("sb_pc", dec.out_pc, e.pc);
        chk("sb_inst", dec.out_inst, e.inst);
        chk("sb_pc4", dec.out_pc4, e.pc + 32'd4);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    dec.out_ready = 1'b1;
    step();
    step();
    chk("rst_valid", 32'(dec.out_valid), 32'd0);
    chk("rst_pc", dec.out_pc, 32'd0);
    chk("rst_inst", dec.out_inst, 32'd0);
    chk("rst_fault", 32'(fault), 32'd0);
    chk("rst_addr", im_addr, 32'd0);

    // 1: streaming from reset
    push(32'h0); push(32'h4); push(32'h8); push(32'hC);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("t1_valid", 32'(dec.out_valid), 32'd1);
      chk("t1_pc", dec.out_pc, 32'(i * 4));
      chk("t1_pc4", dec.out_pc4, 32'(i * 4 + 4));
    end
    chk("t1_inst", dec.out_inst, 32'h44);

    // restart at 0 for the stall case
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0;
    step();
    redirect_valid = 1'b0;
    chk("rd0_valid", 32'(dec.out_valid), 32'd0);
    chk("rd0_addr", im_addr, 32'h0);
    push(32'h0); push(32'h4); push(32'h8);
    step();
    step();
    chk("t2_pre_pc", dec.out_pc, 32'h4);

    // 2: stall 3 cycles
    dec.out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("t2_pc", dec.out_pc, 32'h4);
      chk("t2_inst", dec.out_inst, 32'h22);
      chk("t2_addr", im_addr, 32'h8);
      chk("t2_valid", 32'(dec.out_valid), 32'd1);
    end
    dec.out_ready = 1'b1;
    step();
    chk("t2_next_pc", dec.out_pc, 32'h8);
    step();
    chk("t2_c_pc", dec.out_pc, 32'hC);

    // 3: redirect flushes a held, unaccepted word
    dec.out_ready  = 1'b0;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h40;
    step();
    redirect_valid = 1'b0;
    chk("t3_valid", 32'(dec.out_valid), 32'd0);
    chk("t3_addr", im_addr, 32'h40);
    dec.out_ready = 1'b1;
    push(32'h40);
    step();
    chk("t3_pc", dec.out_pc, 32'h40);
    chk("t3_inst", dec.out_inst, 32'hA000_0010);

    // 4: misaligned redirect traps, redirect recovers
    redirect_valid = 1'b1;
    redirect_pc    = 32'h42;
    step();
    redirect_valid = 1'b0;
    step();
    chk("t4_fault", 32'(fault), 32'd1);
    chk("t4_fpc", fault_pc, 32'h42);
    chk("t4_valid", 32'(dec.out_valid), 32'd0);
    step();
    chk("t4_hold_valid", 32'(dec.out_valid), 32'd0);
    chk("t4_hold_addr", im_addr, 32'h42);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0;
    push(32'h0); push(32'h4);
    step();
    redirect_valid = 1'b0;
    chk("t4_clear", 32'(fault), 32'd0);
    chk("t4_keep_fpc", fault_pc, 32'h42);
    step();
    chk("t4_pc0", dec.out_pc, 32'h0);
    step();
    chk("t4_pc4", dec.out_pc, 32'h4);

    // 5: run off the end of im
    for (int a = 8; a < NMEM * 4; a += 4) push(32'(a));
    repeat (254) step();
    chk("t5_last_pc", dec.out_pc, 32'h3FC);
    chk("t5_last_valid", 32'(dec.out_valid), 32'd1);
    step();
    chk("t5_fault", 32'(fault), 32'd1);
    chk("t5_fpc", fault_pc, 32'h400);
    chk("t5_valid", 32'(dec.out_valid), 32'd0);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("t5_no_valid", 32'(dec.out_valid), 32'd0);
    end
    chk("t5_sb_empty", 32'(q.size()), 32'd0);

    // 6: reset while faulted and stalled
    dec.out_ready = 1'b0;
    rst = 1'b1;
    step();
    chk("t6_valid", 32'(dec.out_valid), 32'd0);
    chk("t6_pc", dec.out_pc, 32'd0);
    chk("t6_inst", dec.out_inst, 32'd0);
    chk("t6_pc4", dec.out_pc4, 32'd0);
    chk("t6_fault", 32'(fault), 32'd0);
    chk("t6_fpc", fault_pc, 32'd0);
    chk("t6_addr", im_addr, 32'd0);
    rst = 1'b0;
    dec.out_ready = 1'b1;
    push(32'h0); push(32'h4); push(32'h8);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("t6_run_pc", dec.out_pc, 32'(i * 4));
    end
    @(negedge clk);
    #1;
    dec.out_ready = 1'b0;
    step();
    chk("t6_sb_empty", 32'(q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
